// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer for the combinational one_bit_alu slice: feeds operand
// bits LSB first, recirculates the slice carry and assembles the result word.
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             alu_a_o,
    output logic             alu_b_o,
    output logic             alu_carry_o,
    output logic [3:0]       alu_f_o,
    input  logic             alu_result_i,
    input  logic             alu_carry_i
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        alu_a_o     = 1'b0;
        alu_b_o     = 1'b0;
        alu_carry_o = 1'b0;
        alu_f_o     = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    // op[3] seeds the carry so B-A becomes B + ~A + 1
                    carry_d = op_i[3];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy_o      = 1'b1;
                alu_a_o     = a_sh_q[0];
                alu_b_o     = b_sh_q[0];
                alu_carry_o = carry_q;
                alu_f_o     = op_q;
                res_sh_d    = {alu_result_i, res_sh_q[WIDTH-1:1]};
                carry_d     = alu_carry_i;
                a_sh_d      = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                result_d    = res_sh_q;
                carry_out_d = (op_q[1:0] == 2'b11) ? carry_q : 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result_o = result_q;
    assign carry_o  = carry_out_q;

endmodule
